// File: rtl/bht_counter_mem.sv
// Branch history table counter storage: a self-clearing row memory of 2-bit
// saturating counters with a hold-last-read port, a handshaked write port and a prediction bit.
module bht_counter_mem #(
   parameter int          els_p      = 16,
   parameter int          row_els_p  = 2,
   parameter logic [1:0]  init_val_p = 2'b01,
   localparam int addr_w_lp   = $clog2(els_p),
   localparam int cnt_w_lp    = $clog2(els_p + 1),
   localparam int offset_w_lp = (row_els_p > 1) ? $clog2(row_els_p) : 1,
   localparam int row_w_lp    = 2 * row_els_p
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   output logic                   init_done_o,
   input  logic                   w_v_i,
   input  logic [addr_w_lp-1:0]   w_addr_i,
   input  logic [row_w_lp-1:0]    w_data_i,
   output logic                   w_yumi_o,
   input  logic                   r_v_i,
   input  logic [addr_w_lp-1:0]   r_addr_i,
   input  logic [offset_w_lp-1:0] r_offset_i,
   output logic [row_w_lp-1:0]    r_data_o,
   output logic                   pred_o
);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   localparam logic [row_w_lp-1:0] init_row_lp = {row_els_p{init_val_p}};

   state_e                  state_r;
   state_e                  state_nxt_s;
   logic [cnt_w_lp-1:0]     init_cnt_r;
   logic [row_w_lp-1:0]     mem_r [els_p];
   logic [row_w_lp-1:0]     r_data_r;
   logic [offset_w_lp-1:0]  offset_r;
   logic                    collision_s;
   logic                    w_yumi_s;
   logic                    mem_we_s;
   logic [addr_w_lp-1:0]    mem_waddr_s;
   logic [row_w_lp-1:0]     mem_wdata_s;
   logic                    pred_s;

   // State register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_r <= ST_RESET;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: one pass of CLEAR over every row, then RUN forever
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RESET: state_nxt_s = ST_CLEAR;
         ST_CLEAR: begin
            if (init_cnt_r == cnt_w_lp'(els_p - 1)) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         ST_RUN:   state_nxt_s = ST_RUN;
         default:  state_nxt_s = ST_RESET;
      endcase
   end

   // Init counter walks the rows during CLEAR and saturates instead of wrapping
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         init_cnt_r <= '0;
      end else if ((state_r == ST_CLEAR) && (init_cnt_r != cnt_w_lp'(els_p))) begin
         init_cnt_r <= init_cnt_r + cnt_w_lp'(1);
      end else begin
         init_cnt_r <= init_cnt_r;
      end
   end

   // Write port arbitration: clear writes always win, and a same-row read blocks a user write
   always_comb begin
      collision_s = r_v_i & w_v_i & (r_addr_i == w_addr_i);
      w_yumi_s    = (state_r == ST_RUN) & w_v_i & ~collision_s;
      mem_we_s    = 1'b0;
      mem_waddr_s = w_addr_i;
      mem_wdata_s = w_data_i;
      if (state_r == ST_CLEAR) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = init_cnt_r[addr_w_lp-1:0];
         mem_wdata_s = init_row_lp;
      end else if (w_yumi_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = w_addr_i;
         mem_wdata_s = w_data_i;
      end else begin
         mem_we_s    = 1'b0;
      end
   end

   // Counter storage; contents are rebuilt by CLEAR rather than reset
   always_ff @(posedge clk_i) begin
      if (mem_we_s) begin
         mem_r[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Read data register holds the last read row while r_v_i is low
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_data_r <= '0;
      end else if (r_v_i) begin
         r_data_r <= mem_r[r_addr_i];
      end else begin
         r_data_r <= r_data_r;
      end
   end

   // Offset is captured every edge so it lines up with r_data_r
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         offset_r <= '0;
      end else begin
         offset_r <= r_offset_i;
      end
   end

   // Prediction is the direction (upper) bit of the selected counter
   generate
      if (row_els_p == 1) begin : g_pred_single
         assign pred_s = r_data_r[1];
      end else begin : g_pred_multi
         always_comb begin
            pred_s = r_data_r[{offset_r, 1'b1}];
         end
      end
   endgenerate

   assign init_done_o = (state_r == ST_RUN);
   assign w_yumi_o    = w_yumi_s;
   assign r_data_o    = r_data_r;
   assign pred_o      = pred_s;

endmodule

// File: tb/tb_bht_counter_mem.sv
// Self-checking bench for bht_counter_mem: directed scenarios plus random traffic
// compared against a row-array reference model of the table.
module tb_bht_counter_mem;

   localparam int ELS = 16;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       init_done_o;
   logic       w_v_i = 1'b0;
   logic [3:0] w_addr_i = 4'd0;
   logic [3:0] w_data_i = 4'd0;
   logic       w_yumi_o;
   logic       r_v_i = 1'b0;
   logic [3:0] r_addr_i = 4'd0;
   logic       r_offset_i = 1'b0;
   logic [3:0] r_data_o;
   logic       pred_o;

   int total = 0;
   int bad = 0;

   logic [3:0] model_mem [ELS];
   logic [3:0] exp_rd = 4'd0;
   logic       exp_off = 1'b0;
   bit         model_run = 1'b0;

   bht_counter_mem #(.els_p(16), .row_els_p(2), .init_val_p(2'b01)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .init_done_o(init_done_o),
      .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_yumi_o(w_yumi_o),
      .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_offset_i(r_offset_i),
      .r_data_o(r_data_o), .pred_o(pred_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic pred_of(logic [3:0] d, logic o);
      int sh;
      sh = 2 * int'(o) + 1;
      return 1'((d >> sh) & 4'd1);
   endfunction

   function automatic logic exp_yumi();
      return model_run && w_v_i && !(r_v_i && (r_addr_i == w_addr_i));
   endfunction

   // Advance one clock, applying the table's rules to the model, and land 1 ns after the edge.
   task automatic tick();
      if (r_v_i) exp_rd = model_mem[r_addr_i];
      if (exp_yumi()) model_mem[w_addr_i] = w_data_i;
      exp_off = r_offset_i;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      w_v_i = 1'b1; w_addr_i = 4'd2; w_data_i = 4'hA;
      #12;
      total++; if (init_done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", init_done_o); end
      total++; if (r_data_o !== 4'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", r_data_o); end
      total++; if (w_yumi_o !== 1'b0) begin bad++; $display("FAIL reset_yumi got=%b exp=0", w_yumi_o); end
      total++; if (pred_o !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b exp=0", pred_o); end
      w_v_i = 1'b0;
   endtask

   // Release reset, watch the clear sequence, optionally poke writes during it, then read every row.
   task automatic test_clear(input bit wr_during);
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      for (int e = 1; e <= ELS + 1; e++) begin
         tick();
         total++;
         if (init_done_o !== (e == ELS + 1)) begin
            bad++; $display("FAIL clear_done edge=%0d got=%b exp=%b", e, init_done_o, (e == ELS + 1));
         end
         if (wr_during && e == 4) begin
            w_v_i = 1'b1; w_addr_i = 4'd9; w_data_i = 4'hF;
         end
         if (e == ELS) w_v_i = 1'b0;
         #1;
         if (w_v_i) begin
            total++;
            if (w_yumi_o !== 1'b0) begin bad++; $display("FAIL clear_yumi edge=%0d got=%b exp=0", e, w_yumi_o); end
         end
      end
      for (int i = 0; i < ELS; i++) model_mem[i] = 4'b0101;
      model_run = 1'b1;
      for (int r = 0; r < ELS; r++) begin
         r_v_i = 1'b1; r_addr_i = 4'(r);
         tick();
         total++;
         if (r_data_o !== exp_rd || exp_rd !== 4'b0101) begin
            bad++; $display("FAIL clear_row row=%0d got=%h exp=%h", r, r_data_o, exp_rd);
         end
      end
      r_v_i = 1'b0;
   endtask

   task automatic test_write_read();
      w_v_i = 1'b1; w_addr_i = 4'd3; w_data_i = 4'b1001;
      #1;
      total++; if (w_yumi_o !== exp_yumi()) begin bad++; $display("FAIL wr_yumi got=%b exp=%b", w_yumi_o, exp_yumi()); end
      tick();
      w_v_i = 1'b0;
      r_v_i = 1'b1; r_addr_i = 4'd3; r_offset_i = 1'b0;
      tick();
      r_v_i = 1'b0;
      total++; if (r_data_o !== exp_rd) begin bad++; $display("FAIL wr_rdata got=%h exp=%h", r_data_o, exp_rd); end
      total++; if (pred_o !== pred_of(exp_rd, exp_off)) begin bad++; $display("FAIL wr_pred0 got=%b exp=%b", pred_o, pred_of(exp_rd, exp_off)); end
      r_offset_i = 1'b1;
      tick();
      total++; if (pred_o !== pred_of(exp_rd, exp_off)) begin bad++; $display("FAIL wr_pred1 got=%b exp=%b", pred_o, pred_of(exp_rd, exp_off)); end
      r_offset_i = 1'b0;
   endtask

   task automatic test_collision();
      w_v_i = 1'b1; w_addr_i = 4'd5; w_data_i = 4'hF;
      r_v_i = 1'b1; r_addr_i = 4'd5;
      #1;
      total++; if (w_yumi_o !== exp_yumi()) begin bad++; $display("FAIL coll_yumi got=%b exp=%b", w_yumi_o, exp_yumi()); end
      tick();
      w_v_i = 1'b0;
      total++; if (r_data_o !== exp_rd) begin bad++; $display("FAIL coll_rdata got=%h exp=%h", r_data_o, exp_rd); end
      tick();
      r_v_i = 1'b0;
      total++; if (r_data_o !== exp_rd) begin bad++; $display("FAIL coll_reread got=%h exp=%h", r_data_o, exp_rd); end
   endtask

   task automatic test_hold();
      r_v_i = 1'b1; r_addr_i = 4'd3;
      tick();
      r_v_i = 1'b0;
      total++; if (r_data_o !== exp_rd) begin bad++; $display("FAIL hold_first got=%h exp=%h", r_data_o, exp_rd); end
      w_v_i = 1'b1; w_addr_i = 4'd7; w_data_i = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (w_yumi_o !== exp_yumi()) begin bad++; $display("FAIL hold_yumi cyc=%0d got=%b exp=%b", c, w_yumi_o, exp_yumi()); end
         tick();
         total++; if (r_data_o !== exp_rd) begin bad++; $display("FAIL hold_rdata cyc=%0d got=%h exp=%h", c, r_data_o, exp_rd); end
      end
      w_v_i = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         r_v_i = 1'($urandom_range(0, 1));
         w_v_i = 1'($urandom_range(0, 1));
         r_addr_i = 4'($urandom_range(0, 15));
         w_addr_i = ($urandom_range(0, 3) == 0) ? r_addr_i : 4'($urandom_range(0, 15));
         w_data_i = 4'($urandom_range(0, 15));
         r_offset_i = 1'($urandom_range(0, 1));
         #1;
         total++; if (w_yumi_o !== exp_yumi()) begin bad++; $display("FAIL rnd_yumi cyc=%0d got=%b exp=%b", c, w_yumi_o, exp_yumi()); end
         tick();
         total++; if (r_data_o !== exp_rd) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, r_data_o, exp_rd); end
         total++; if (pred_o !== pred_of(exp_rd, exp_off)) begin bad++; $display("FAIL rnd_pred cyc=%0d got=%b exp=%b", c, pred_o, pred_of(exp_rd, exp_off)); end
      end
      r_v_i = 1'b0; w_v_i = 1'b0; r_offset_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_run();
      w_v_i = 1'b1; w_addr_i = 4'd3; w_data_i = 4'b1001;
      tick();
      w_v_i = 1'b0;
      r_v_i = 1'b1; r_addr_i = 4'd3; r_offset_i = 1'b1;
      tick();
      r_v_i = 1'b0;
      total++; if (r_data_o !== 4'b1001) begin bad++; $display("FAIL mid_pre got=%h exp=9", r_data_o); end
      w_v_i = 1'b1; w_addr_i = 4'd8;
      reset_i = 1'b0;
      #2;
      total++; if (init_done_o !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", init_done_o); end
      total++; if (r_data_o !== 4'd0) begin bad++; $display("FAIL mid_rdata got=%h exp=0", r_data_o); end
      total++; if (w_yumi_o !== 1'b0) begin bad++; $display("FAIL mid_yumi got=%b exp=0", w_yumi_o); end
      total++; if (pred_o !== 1'b0) begin bad++; $display("FAIL mid_pred got=%b exp=0", pred_o); end
      w_v_i = 1'b0; r_offset_i = 1'b0;
      exp_rd = 4'd0; exp_off = 1'b0; model_run = 1'b0;
      test_clear(1'b0);
   endtask

   initial begin
      test_reset();
      test_clear(1'b1);
      test_write_read();
      test_collision();
      test_hold();
      test_random();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
